// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM access arbiter.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (round-robin conflict resolution).
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LD
  } owner_t;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ROM_WORDS = 4096;
  localparam int ROM_BYTES = ROM_WORDS * 4;

  // Word-aligned and inside the ROM byte range.
  function automatic logic addr_legal(
    input logic [63:0] addr,
    input logic [63:0] rom_bytes
  );
    return (addr[1:0] == 2'b00) && (addr < rom_bytes);
  endfunction

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester-side ROM access port (req/gnt plus one-cycle response).
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (used by the arbiter only).
interface rom_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/rom_arb_picker.sv
// Two-way combinational grant picker for the ROM arbiter.
// ROM_ARB_ROUND_ROBIN_EN: rr_last input breaks ties, else IF wins.
module rom_arb_picker (
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  logic rr_last,
`endif
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);

  logic if_wins;

  // Tie-break: rr_last high means LD was granted last, so IF wins.
  always_comb begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
    if_wins = rr_last;
`else
    if_wins = 1'b1;
`endif
    if_gnt = if_req && (!ld_req || if_wins);
    ld_gnt = ld_req && !if_gnt;
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read ROM between instruction fetch and loads.
// ROM_ARB_ROUND_ROBIN_EN: alternate conflict winner instead of IF first.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  rom_access_arbiter_if.slave if_port,
  rom_access_arbiter_if.slave ld_port,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [63:0] LIM =
    64'(ROM_WORDS) * 64'd4;

  owner_t owner_q, owner_d;
  logic   err_q, err_d;
  logic   pick_if, pick_ld;
  logic   gnt_if, gnt_ld, any_gnt, legal;
  logic [ADDR_W-1:0] sel_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic rr_last;

  // Remember who won the most recent grant (1 = LD).
  always_ff @(posedge clk) begin
    if (rst)          rr_last <= 1'b0;
    else if (any_gnt) rr_last <= gnt_ld;
  end
`endif

  rom_arb_picker u_pick (
`ifdef ROM_ARB_ROUND_ROBIN_EN
    .rr_last (rr_last),
`endif
    .if_req  (if_port.req),
    .ld_req  (ld_port.req),
    .if_gnt  (pick_if),
    .ld_gnt  (pick_ld)
  );

  // Grant, legality check and ROM drive for this cycle.
  always_comb begin
    gnt_if   = pick_if && !rst;
    gnt_ld   = pick_ld && !rst;
    any_gnt  = gnt_if || gnt_ld;
    sel_addr = gnt_if ? if_port.addr
                      : ld_port.addr;
    legal    = addr_legal(64'(sel_addr), LIM);
    if_port.gnt = gnt_if;
    ld_port.gnt = gnt_ld;
    rom_enable  = any_gnt && legal;
    rom_address = rom_enable ? sel_addr : '0;
  end

  // Next response owner and error flag.
  always_comb begin
    owner_d = OWN_NONE;
    err_d   = 1'b0;
    unique case (1'b1)
      gnt_if:  owner_d = OWN_IF;
      gnt_ld:  owner_d = OWN_LD;
      default: owner_d = OWN_NONE;
    endcase
    err_d = any_gnt && !legal;
  end

  // Response pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Route the ROM word (or an error) to its owner.
  always_comb begin
    if_port.rvalid = (owner_q == OWN_IF);
    ld_port.rvalid = (owner_q == OWN_LD);
    if_port.err    = if_port.rvalid && err_q;
    ld_port.err    = ld_port.rvalid && err_q;
    if_port.rdata  = '0;
    ld_port.rdata  = '0;
    if (if_port.rvalid && !err_q)
      if_port.rdata = rom_data;
    if (ld_port.rvalid && !err_q)
      ld_port.rdata = rom_data;
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a response scoreboard.
// Honours ROM_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_rom_access_arbiter;

  typedef struct {
    bit          is_ld;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data = '0;

  int total = 0;
  int bad   = 0;
  rsp_t q[$];
  bit rr_ld = 1'b0;
  bit last_gi, last_gl;

  rom_access_arbiter_if #(32, 32) if_bus ();
  rom_access_arbiter_if #(32, 32) ld_bus ();

  rom_access_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .ROM_WORDS (4096)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_port     (if_bus),
    .ld_port     (ld_bus),
    .rom_enable  (rom_enable),
    .rom_address (rom_address),
    .rom_data    (rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(
    input logic [31:0] a
  );
    return 32'hC0DE_0000 | {20'd0, a[13:2]};
  endfunction

  // Synchronous-read ROM model.
  always @(posedge clk)
    if (rom_enable) rom_data <= word(rom_address);

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input bit          r,
    input bit          ifr,
    input logic [31:0] ifa,
    input bit          ldr,
    input logic [31:0] lda
  );
    rsp_t e;
    bit ev_if, ev_ld, eerr, gi, gl, lg, prio;
    logic [31:0] ed, a;
    @(negedge clk);
    rst         = r;
    if_bus.req  = ifr;
    if_bus.addr = ifa;
    ld_bus.req  = ldr;
    ld_bus.addr = lda;
    #1;
    ev_if = 0; ev_ld = 0; eerr = 0; ed = '0;
    if (q.size() > 0) begin
      e     = q.pop_front();
      ev_if = !e.is_ld;
      ev_ld = e.is_ld;
      eerr  = e.err;
      ed    = e.data;
    end
    chk("if_rvalid", 32'(if_bus.rvalid), 32'(ev_if));
    chk("ld_rvalid", 32'(ld_bus.rvalid), 32'(ev_ld));
    chk("if_err", 32'(if_bus.err), 32'(ev_if & eerr));
    chk("ld_err", 32'(ld_bus.err), 32'(ev_ld & eerr));
    chk("if_rdata", if_bus.rdata, ev_if ? ed : 32'd0);
    chk("ld_rdata", ld_bus.rdata, ev_ld ? ed : 32'd0);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    prio = rr_ld;
`else
    prio = 1'b1;
`endif
    gi = !r && ifr && (!ldr || prio);
    gl = !r && ldr && !gi;
    a  = gi ? ifa : lda;
    lg = (a[1:0] == 2'b00) && (a < 32'h4000);
    chk("if_gnt", 32'(if_bus.gnt), 32'(gi));
    chk("ld_gnt", 32'(ld_bus.gnt), 32'(gl));
    chk("rom_enable", 32'(rom_enable),
        32'((gi | gl) & lg));
    if (!(gi | gl) || lg)
      chk("rom_address", rom_address,
          ((gi | gl) && lg) ? a : 32'd0);
    if (gi | gl)
      q.push_back('{gl, !lg, lg ? word(a) : 32'd0});
    if (r)            rr_ld = 1'b0;
    else if (gi | gl) rr_ld = gl;
    last_gi = gi;
    last_gl = gl;
  endtask

  initial begin
    if_bus.req = 0; if_bus.addr = '0;
    ld_bus.req = 0; ld_bus.addr = '0;
    repeat (2) @(posedge clk);
    // reset state
    step(1, 0, 0, 0, 0);
    // 1: IF back-to-back
    step(0, 1, 32'h0, 0, 0);
    step(0, 1, 32'h4, 0, 0);
    step(0, 1, 32'h8, 0, 0);
    step(0, 0, 0, 0, 0);
    // 2: conflict, loser granted next
    step(0, 1, 32'h10, 1, 32'h20);
    step(0, !last_gi, 32'h10, !last_gl, 32'h20);
    step(0, 0, 0, 0, 0);
    // 3: conflict held four cycles
    repeat (4) step(0, 1, 32'h10, 1, 32'h20);
    step(0, 0, 0, 0, 0);
    // 4: out of range, misaligned
    step(0, 0, 0, 1, 32'h0000_4000);
    step(0, 0, 0, 1, 32'h6);
    step(0, 0, 0, 1, 32'h3FFC);
    step(0, 0, 0, 0, 0);
    // 5: reset after an IF grant
    step(0, 1, 32'h40, 0, 0);
    step(1, 1, 32'h44, 1, 32'h48);
    step(0, 0, 0, 0, 0);
    // 6: idle
    repeat (3) step(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
